alu_req_sequencer: RTL and testbench

- Shares one combinational ALU (ADD/SUB/SRA/SRL/SLL/AND/OR) between two requesters using round-robin arbitration.
- Sequences multi-bit shifts on the ALU's single-bit shifter: one ALU pass per shift position.
- Returns each result on one registered response port, tagged with the requester ID.
- Sits between the requesters and the ALU datapath; the ALU's own op decoder stays unchanged.

---
 rtl/alu_req_sequencer_if.sv | 43 ++++
 rtl/alu_req_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_req_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_req_sequencer_if.sv
// Requester, ALU and response bundle for alu_req_sequencer.
// master = environment side, slave = sequencer side.
interface alu_req_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             REQ0_VALID;
  logic             REQ0_READY;
  logic [2:0]       REQ0_OP;
  logic [WIDTH-1:0] REQ0_A;
  logic [WIDTH-1:0] REQ0_B;
  logic             REQ1_VALID;
  logic             REQ1_READY;
  logic [2:0]       REQ1_OP;
  logic [WIDTH-1:0] REQ1_A;
  logic [WIDTH-1:0] REQ1_B;
  logic [2:0]       ALU_OP;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [WIDTH-1:0] ALU_RESULT;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic             RSP_ID;
  logic [WIDTH-1:0] RSP_DATA;
  logic             BUSY;

  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
    output REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
    output ALU_RESULT, RSP_READY,
    input  REQ0_READY, REQ1_READY,
    input  ALU_OP, ALU_A, ALU_B,
    input  RSP_VALID, RSP_ID, RSP_DATA, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
    input  REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
    input  ALU_RESULT, RSP_READY,
    output REQ0_READY, REQ1_READY,
    output ALU_OP, ALU_A, ALU_B,
    output RSP_VALID, RSP_ID, RSP_DATA, BUSY
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Round-robin sharing of one ALU between two requesters;
// multi-bit shifts are walked one ALU pass per position.
module alu_req_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic CLK,
  input logic RESET,
  alu_req_sequencer_if.slave bus
);

  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    RESP
  } state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   cnt_q;
  logic             last_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             idle;
  logic             gnt0;
  logic             gnt1;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             pass_now;
  logic             shift_now;
  logic             alu_on;

  assign idle = (state_q == IDLE) && !RESET;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = idle && bus.REQ0_VALID &&
                (!bus.REQ1_VALID || last_q);
  assign gnt1 = idle && bus.REQ1_VALID &&
                (!bus.REQ0_VALID || !last_q);

  assign sel_op = gnt1 ? bus.REQ1_OP : bus.REQ0_OP;
  assign sel_a  = gnt1 ? bus.REQ1_A  : bus.REQ0_A;
  assign sel_b  = gnt1 ? bus.REQ1_B  : bus.REQ0_B;
  assign shamt  = sel_b[SHW-1:0];

  assign is_shift  = (sel_op == OP_SRA) ||
                     (sel_op == OP_SRL) ||
                     (sel_op == OP_SLL);
  assign pass_now  = (sel_op == OP_PASS) ||
                     (is_shift && shamt == '0);
  assign shift_now = is_shift && shamt != '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_q     <= sel_op;
            acc_q    <= sel_a;
            b_q      <= sel_b;
            cnt_q    <= shamt;
            last_q   <= gnt1;
            rsp_id_q <= gnt1;
            unique case (1'b1)
              pass_now: begin
                rsp_data_q  <= sel_a;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
              shift_now: state_q <= SHIFT;
              default:   state_q <= EXEC;
            endcase
          end
        end
        EXEC: begin
          rsp_data_q  <= bus.ALU_RESULT;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        SHIFT: begin
          acc_q <= bus.ALU_RESULT;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            rsp_data_q  <= bus.ALU_RESULT;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ALU inputs are forced to zero whenever no pass is in progress.
  assign alu_on = (state_q == EXEC) || (state_q == SHIFT);

  assign bus.ALU_OP = alu_on ? op_q  : '0;
  assign bus.ALU_A  = alu_on ? acc_q : '0;
  assign bus.ALU_B  = (state_q == EXEC) ? b_q : '0;

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign bus.RSP_VALID  = rsp_valid_q;
  assign bus.RSP_ID     = rsp_id_q;
  assign bus.RSP_DATA   = rsp_data_q;
  assign bus.BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed plus random checks of alu_req_sequencer against
// a result/latency model and a single-bit-shift ALU.
module tb_alu_req_sequencer;

  localparam int W = 32;
  localparam int S = 5;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  alu_req_sequencer_if #(.WIDTH(W)) bus ();

  alu_req_sequencer #(.WIDTH(W), .SHW(S)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // ALU datapath: shifts move exactly one position per pass.
  always_comb begin
    bus.ALU_RESULT = '0;
    case (bus.ALU_OP)
      3'd0: bus.ALU_RESULT = bus.ALU_A + bus.ALU_B;
      3'd1: bus.ALU_RESULT = bus.ALU_A - bus.ALU_B;
      3'd2: bus.ALU_RESULT = {bus.ALU_A[W-1], bus.ALU_A[W-1:1]};
      3'd3: bus.ALU_RESULT = {1'b0, bus.ALU_A[W-1:1]};
      3'd4: bus.ALU_RESULT = {bus.ALU_A[W-2:0], 1'b0};
      3'd5: bus.ALU_RESULT = bus.ALU_A & bus.ALU_B;
      3'd6: bus.ALU_RESULT = bus.ALU_A | bus.ALU_B;
      default: bus.ALU_RESULT = bus.ALU_A;
    endcase
  end

  int errors = 0;
  int checks = 0;
  bit lastg;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sh(logic [2:0] op);
    return op == 3'd2 || op == 3'd3 || op == 3'd4;
  endfunction

  function automatic logic [W-1:0] model(logic [2:0] op,
      logic [W-1:0] a, logic [W-1:0] b);
    int sh;
    sh = int'(b[S-1:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return W'($signed(a) >>> sh);
      3'd3: return a >> sh;
      3'd4: return a << sh;
      3'd5: return a & b;
      3'd6: return a | b;
      default: return a;
    endcase
  endfunction

  function automatic int lat(logic [2:0] op, logic [W-1:0] b);
    if (op == 3'd7) return 1;
    if (is_sh(op)) return (b[S-1:0] == 0) ? 1 : int'(b[S-1:0]) + 1;
    return 2;
  endfunction

  task automatic idle_inputs();
    bus.REQ0_VALID = 0; bus.REQ0_OP = 0;
    bus.REQ0_A = 0; bus.REQ0_B = 0;
    bus.REQ1_VALID = 0; bus.REQ1_OP = 0;
    bus.REQ1_A = 0; bus.REQ1_B = 0;
    bus.RSP_READY = 0;
  endtask

  task automatic run(input bit v0, input bit v1,
      input logic [2:0] op0, input logic [W-1:0] a0, b0,
      input logic [2:0] op1, input logic [W-1:0] a1, b1,
      input int hold);
    bit w;
    logic [2:0] op;
    logic [W-1:0] a, b, expd;
    int c, busy, el;
    w = (v0 && v1) ? ~lastg : !v0;
    lastg = w;
    op = w ? op1 : op0;
    a  = w ? a1 : a0;
    b  = w ? b1 : b0;
    el = lat(op, b);
    expd = model(op, a, b);
    bus.RSP_READY = 0;
    bus.REQ0_VALID = v0; bus.REQ0_OP = op0;
    bus.REQ0_A = a0; bus.REQ0_B = b0;
    bus.REQ1_VALID = v1; bus.REQ1_OP = op1;
    bus.REQ1_A = a1; bus.REQ1_B = b1;
    #1;
    chk("ready0", W'(bus.REQ0_READY), W'(!w));
    chk("ready1", W'(bus.REQ1_READY), W'(w));
    @(posedge CLK); #1;
    bus.REQ0_A = $urandom; bus.REQ0_B = $urandom;
    bus.REQ1_A = $urandom; bus.REQ1_B = $urandom;
    c = 1; busy = 0;
    while (!bus.RSP_VALID && c < 100) begin
      busy++;
      #1;
      chk("alu_op", W'(bus.ALU_OP), W'(op));
      chk("alu_b", bus.ALU_B, is_sh(op) ? '0 : b);
      if (c == 1) chk("alu_a", bus.ALU_A, a);
      chk("ready_busy", W'({bus.REQ0_READY, bus.REQ1_READY}), 0);
      @(posedge CLK); #1;
      c++;
    end
    chk("latency", c, el);
    for (int h = 0; h <= hold; h++) begin
      busy++;
      #1;
      chk("rsp_valid", W'(bus.RSP_VALID), 1);
      chk("rsp_data", bus.RSP_DATA, expd);
      chk("rsp_id", W'(bus.RSP_ID), W'(w));
      chk("alu_quiet", W'(bus.ALU_OP) | bus.ALU_A | bus.ALU_B, 0);
      chk("ready_resp", W'({bus.REQ0_READY, bus.REQ1_READY}), 0);
      if (h == hold) bus.RSP_READY = 1;
      @(posedge CLK); #1;
    end
    chk("rsp_drop", W'(bus.RSP_VALID), 0);
    chk("busy_drop", W'(bus.BUSY), 0);
    chk("busy_cycles", busy, el + hold);
    idle_inputs();
  endtask

  initial begin
    logic [2:0] rop0, rop1;
    idle_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    lastg = 1;
    chk("rst_busy", W'(bus.BUSY), 0);
    chk("rst_rsp", W'({bus.RSP_VALID, bus.RSP_ID}), 0);
    chk("rst_data", bus.RSP_DATA, 0);
    chk("rst_alu", W'(bus.ALU_OP) | bus.ALU_A | bus.ALU_B, 0);

    run(1, 0, 3'd0, 5, 7, 3'd0, 0, 0, 0);
    run(1, 1, 3'd5, 32'hF0F0, 32'h0FF0, 3'd6, 32'h1, 32'h2, 0);
    run(1, 1, 3'd0, 32'hFFFFFFFF, 1, 3'd1, 0, 1, 0);
    run(1, 1, 3'd6, 32'hA0, 32'h0B, 3'd0, 9, 9, 0);
    run(0, 1, 3'd0, 0, 0, 3'd3, 32'h80000000, 4, 1);
    run(1, 0, 3'd2, 32'h80000000, 31, 3'd0, 0, 0, 0);
    run(0, 1, 3'd0, 0, 0, 3'd4, 32'h1234ABCD, 0, 0);
    run(1, 0, 3'd7, 32'hDEADBEEF, 5, 3'd0, 0, 0, 0);
    run(1, 0, 3'd1, 3, 5, 3'd0, 0, 0, 5);

    // Reset mid-shift: drop the command, re-arm tie order.
    bus.REQ0_VALID = 1; bus.REQ0_OP = 3'd3;
    bus.REQ0_A = $urandom; bus.REQ0_B = 10;
    @(posedge CLK); #1;
    idle_inputs();
    repeat (7) @(posedge CLK);
    #1 RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    chk("mid_rst_busy", W'(bus.BUSY), 0);
    chk("mid_rst_rsp", W'({bus.RSP_VALID, bus.RSP_ID}), 0);
    chk("mid_rst_data", bus.RSP_DATA, 0);
    chk("mid_rst_alu", W'(bus.ALU_OP) | bus.ALU_A | bus.ALU_B, 0);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("mid_rst_norsp", W'({bus.RSP_VALID, bus.BUSY}), 0);
    end
    lastg = 1;
    run(1, 1, 3'd0, 100, 23, 3'd1, 7, 7, 0);

    for (int i = 0; i < 30; i++) begin
      bit rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1;
      rop0 = 3'($urandom);
      rop1 = 3'($urandom);
      run(rv0, rv1, rop0, $urandom, $urandom,
          rop1, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
